// File: rtl/instr_encoder_loader_pkg.sv
// Shared KGP-RISC encoding constants, formats and error codes.
// Field positions match those the decode stage unpacks.
package instr_encoder_loader_pkg;

    localparam logic [5:0] OP_LW   = 6'b001110;
    localparam logic [5:0] OP_SW   = 6'b001111;
    localparam logic [5:0] OP_ADDI = 6'b010000;
    localparam logic [5:0] OP_COMI = 6'b010001;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 26;
    localparam int RS_HI  = 25;
    localparam int RS_LO  = 21;
    localparam int RT_HI  = 20;
    localparam int RT_LO  = 16;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_RANGE = 2'd1;
    localparam logic [1:0] ERR_FMT   = 2'd2;
    localparam logic [1:0] ERR_OVF   = 2'd3;

    typedef enum logic [1:0] {
        FMT_R16 = 2'd0,
        FMT_S16 = 2'd1,
        FMT_I21 = 2'd2,
        FMT_J26 = 2'd3
    } fmt_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } state_e;

endpackage

// File: rtl/instr_encoder_loader_packer.sv
// Combinational field packer: builds the 32-bit word and
// reports immediate range and format/opcode consistency.
module instr_field_packer
    import instr_encoder_loader_pkg::*;
(
    input  fmt_e        fmt,
    input  logic [5:0]  opcode,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        range_ok,
    output logic        fmt_ok
);

    logic is_ls;
    logic is_ai;

    assign is_ls = (opcode == OP_LW) || (opcode == OP_SW);
    assign is_ai = (opcode == OP_ADDI) || (opcode == OP_COMI);

    // Pack fields into the decode-stage word layout
    always_comb begin
        word = '0;
        word[OPC_HI:OPC_LO] = opcode;
        unique case (fmt)
            FMT_R16, FMT_S16: begin
                word[RS_HI:RS_LO] = rs;
                word[RT_HI:RT_LO] = rt;
                word[15:0]        = imm[15:0];
            end
            FMT_I21: begin
                word[RS_HI:RS_LO] = rs;
                word[20:0]        = imm[20:0];
            end
            FMT_J26: begin
                word[25:0] = imm[25:0];
            end
        endcase
    end

    // Immediate fits when all bits above the field agree with its sign rule
    always_comb begin
        range_ok = 1'b0;
        unique case (fmt)
            FMT_R16: range_ok = (imm[31:16] == '0);
            FMT_S16: range_ok = (imm[31:15] == '0) || (imm[31:15] == '1);
            FMT_I21: begin
                if (is_ai)
                    range_ok = (imm[31:20] == '0) || (imm[31:20] == '1);
                else
                    range_ok = (imm[31:21] == '0);
            end
            FMT_J26: range_ok = (imm[31:26] == '0);
        endcase
    end

    // lw/sw pair exclusively with S16; addi/comi demand I21
    always_comb begin
        fmt_ok = 1'b1;
        if (is_ls && (fmt != FMT_S16))
            fmt_ok = 1'b0;
        if ((fmt == FMT_S16) && !is_ls)
            fmt_ok = 1'b0;
        if (is_ai && (fmt != FMT_I21))
            fmt_ok = 1'b0;
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Instruction encoder/loader: accepts field bundles, packs
// them and writes words to instruction memory sequentially.
module instr_encoder_loader
    import instr_encoder_loader_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_fmt,
    input  logic [5:0]        in_opcode,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [31:0]       in_imm,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};

    state_e            state;
    state_e            state_nx;
    logic [31:0]       word;
    logic [31:0]       packed_word;
    logic              range_ok;
    logic              fmt_ok;
    logic              last_q;
    logic [ADDR_W-1:0] addr;
    logic              accept;
    logic              full;
    logic              bad;

    instr_field_packer u_packer (
        .fmt      (fmt_e'(in_fmt)),
        .opcode   (in_opcode),
        .rs       (in_rs),
        .rt       (in_rt),
        .imm      (in_imm),
        .word     (packed_word),
        .range_ok (range_ok),
        .fmt_ok   (fmt_ok)
    );

    // start always wins over a coincident bundle
    assign accept    = in_valid && in_ready && !start;
    assign full      = (count == FULL);
    assign bad       = full || !fmt_ok || !range_ok;
    assign mem_addr  = addr;
    assign mem_wdata = word;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        if (start) begin
            state_nx = ST_RUN;
        end else begin
            unique case (state)
                ST_RUN: begin
                    if (accept)
                        state_nx = bad ? ST_ERROR : ST_WRITE;
                end
                ST_WRITE: state_nx = last_q ? ST_DONE : ST_RUN;
                default:  state_nx = state;
            endcase
        end
    end

    // Moore outputs
    always_comb begin
        in_ready = (state == ST_RUN);
        mem_we   = (state == ST_WRITE);
    end

    // Word latch, address/count advance and sticky flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word     <= '0;
            last_q   <= 1'b0;
            addr     <= '0;
            count    <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
        end else if (start) begin
            addr     <= '0;
            count    <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
        end else if (accept) begin
            if (bad) begin
                err <= 1'b1;
                if (full)
                    err_code <= ERR_OVF;
                else if (!fmt_ok)
                    err_code <= ERR_FMT;
                else
                    err_code <= ERR_RANGE;
            end else begin
                word   <= packed_word;
                last_q <= in_last;
            end
        end else if (state == ST_WRITE) begin
            // hold at the top word; only start/reset wrap the address
            if (addr != {ADDR_W{1'b1}})
                addr <= addr + 1'b1;
            count <= count + 1'b1;
            if (last_q)
                done <= 1'b1;
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader.
// Two instances: default depth and a 4-word one for overflow.
module tb_instr_encoder_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [1:0]  in_fmt = 2'd0;
    logic [5:0]  in_opcode = 6'd0;
    logic [4:0]  in_rs = 5'd0;
    logic [4:0]  in_rt = 5'd0;
    logic [31:0] in_imm = 32'd0;
    logic        in_last = 1'b0;

    logic        in_ready;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [10:0] count;
    logic        done;
    logic        err;
    logic [1:0]  err_code;

    logic        s_in_ready;
    logic        s_mem_we;
    logic [1:0]  s_mem_addr;
    logic [31:0] s_mem_wdata;
    logic [2:0]  s_count;
    logic        s_done;
    logic        s_err;
    logic [1:0]  s_err_code;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instr_encoder_loader #(.ADDR_W(10)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_opcode(in_opcode),
        .in_rs(in_rs), .in_rt(in_rt), .in_imm(in_imm),
        .in_last(in_last), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .count(count), .done(done), .err(err),
        .err_code(err_code)
    );

    instr_encoder_loader #(.ADDR_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_valid(in_valid), .in_ready(s_in_ready),
        .in_fmt(in_fmt), .in_opcode(in_opcode),
        .in_rs(in_rs), .in_rt(in_rt), .in_imm(in_imm),
        .in_last(in_last), .mem_we(s_mem_we),
        .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
        .count(s_count), .done(s_done), .err(s_err),
        .err_code(s_err_code)
    );

    // write log sampled mid-cycle
    logic [9:0]  log_addr [0:15];
    logic [31:0] log_data [0:15];
    int          nwr = 0;
    int          s_nwr = 0;
    logic        prev_we = 1'b0;
    logic        consec = 1'b0;

    always @(negedge clk) begin
        if (mem_we) begin
            if (nwr < 16) begin
                log_addr[nwr] = mem_addr;
                log_data[nwr] = mem_wdata;
            end
            nwr = nwr + 1;
        end
        if (mem_we && prev_we)
            consec = 1'b1;
        prev_we = mem_we;
        if (s_mem_we)
            s_nwr = s_nwr + 1;
    end

    task automatic clear_log();
        nwr = 0;
        s_nwr = 0;
        consec = 1'b0;
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [1:0] f, input logic [5:0] op,
                        input logic [4:0] rs, input logic [4:0] rt,
                        input logic [31:0] imm, input logic last);
        int n;
        in_fmt = f;
        in_opcode = op;
        in_rs = rs;
        in_rt = rt;
        in_imm = imm;
        in_last = last;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 20) begin
            failures++;
            $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({in_ready, mem_we, mem_addr, mem_wdata} !== 44'd0) begin
            failures++;
            $display("FAIL reset_port: rdy=%0b we=%0b addr=%0h wd=%h required 0",
                     in_ready, mem_we, mem_addr, mem_wdata);
        end
        checks++;
        if ({count, done, err, err_code} !== 15'd0) begin
            failures++;
            $display("FAIL reset_status: cnt=%0d done=%0b err=%0b code=%0d required 0",
                     count, done, err, err_code);
        end
        @(negedge clk);
        rst_n = 1'b1;
        settle(2);
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL idle_ready: got %0b required 0", in_ready);
        end
    endtask

    task automatic test_single_lw();
        clear_log();
        do_start();
        send(2'd1, 6'b001110, 5'd3, 5'd5, -32'sd4, 1'b1);
        settle(3);
        checks++;
        if (nwr !== 1 || log_addr[0] !== 10'd0 || log_data[0] !== 32'h3865FFFC) begin
            failures++;
            $display("FAIL lw_write: n=%0d addr=%0h data=%h required 1/0/3865fffc",
                     nwr, log_addr[0], log_data[0]);
        end
        checks++;
        if (count !== 11'd1 || done !== 1'b1 || err !== 1'b0) begin
            failures++;
            $display("FAIL lw_status: cnt=%0d done=%0b err=%0b required 1/1/0",
                     count, done, err);
        end
    endtask

    task automatic test_back_to_back();
        clear_log();
        do_start();
        send(2'd2, 6'b010000, 5'd1, 5'd0, 32'hFFFFFFFF, 1'b0);
        send(2'd0, 6'b000000, 5'd2, 5'd4, 32'd7, 1'b0);
        send(2'd3, 6'b000101, 5'd0, 5'd0, 32'h03FFFFFF, 1'b1);
        settle(3);
        checks++;
        if (nwr !== 3) begin
            failures++;
            $display("FAIL b2b_count_writes: got %0d required 3", nwr);
        end
        checks++;
        if (log_addr[0] !== 10'd0 || log_data[0] !== 32'h403FFFFF) begin
            failures++;
            $display("FAIL b2b_w0: addr=%0h data=%h required 0/403fffff",
                     log_addr[0], log_data[0]);
        end
        checks++;
        if (log_addr[1] !== 10'd1 || log_data[1] !== 32'h00440007) begin
            failures++;
            $display("FAIL b2b_w1: addr=%0h data=%h required 1/00440007",
                     log_addr[1], log_data[1]);
        end
        checks++;
        if (log_addr[2] !== 10'd2 || log_data[2] !== 32'h17FFFFFF) begin
            failures++;
            $display("FAIL b2b_w2: addr=%0h data=%h required 2/17ffffff",
                     log_addr[2], log_data[2]);
        end
        checks++;
        if (consec !== 1'b0 || count !== 11'd3 || done !== 1'b1) begin
            failures++;
            $display("FAIL b2b_status: consec=%0b cnt=%0d done=%0b required 0/3/1",
                     consec, count, done);
        end
    endtask

    task automatic test_range_err();
        clear_log();
        do_start();
        send(2'd1, 6'b001110, 5'd1, 5'd1, 32'd32768, 1'b0);
        settle(3);
        checks++;
        if (err !== 1'b1 || err_code !== 2'd1 || nwr !== 0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL range_err: err=%0b code=%0d n=%0d rdy=%0b required 1/1/0/0",
                     err, err_code, nwr, in_ready);
        end
        do_start();
        checks++;
        if (err !== 1'b0 || err_code !== 2'd0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL range_clear: err=%0b code=%0d rdy=%0b required 0/0/1",
                     err, err_code, in_ready);
        end
    endtask

    task automatic test_fmt_err();
        clear_log();
        do_start();
        send(2'd0, 6'b001111, 5'd1, 5'd2, 32'd5, 1'b0);
        settle(2);
        checks++;
        if (err !== 1'b1 || err_code !== 2'd2 || nwr !== 0) begin
            failures++;
            $display("FAIL fmt_sw_r16: err=%0b code=%0d n=%0d required 1/2/0",
                     err, err_code, nwr);
        end
        do_start();
        send(2'd2, 6'b001110, 5'd1, 5'd2, 32'h00400000, 1'b0);
        settle(2);
        checks++;
        if (err !== 1'b1 || err_code !== 2'd2 || nwr !== 0) begin
            failures++;
            $display("FAIL fmt_wins: err=%0b code=%0d n=%0d required 1/2/0",
                     err, err_code, nwr);
        end
    endtask

    task automatic test_overflow();
        clear_log();
        do_start();
        for (int i = 0; i < 4; i++)
            send(2'd3, 6'b000010, 5'd0, 5'd0, 32'(i), 1'b0);
        settle(1);
        checks++;
        if (s_count !== 3'd4 || s_nwr !== 4 || s_err !== 1'b0) begin
            failures++;
            $display("FAIL ovf_fill: cnt=%0d n=%0d err=%0b required 4/4/0",
                     s_count, s_nwr, s_err);
        end
        send(2'd3, 6'b000010, 5'd0, 5'd0, 32'd9, 1'b0);
        settle(3);
        checks++;
        if (s_err !== 1'b1 || s_err_code !== 2'd3 || s_count !== 3'd4 || s_nwr !== 4) begin
            failures++;
            $display("FAIL ovf_err: err=%0b code=%0d cnt=%0d n=%0d required 1/3/4/4",
                     s_err, s_err_code, s_count, s_nwr);
        end
    endtask

    task automatic test_reset_mid();
        do_start();
        in_fmt = 2'd3;
        in_opcode = 6'b000101;
        in_imm = 32'h00ABCDEF;
        in_last = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_last = 1'b0;
        checks++;
        if (mem_we !== 1'b1) begin
            failures++;
            $display("FAIL mid_we_before: got %0b required 1", mem_we);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_we, in_ready, mem_addr, mem_wdata, count, done, err, err_code} !== 59'd0) begin
            failures++;
            $display("FAIL mid_reset: we=%0b rdy=%0b wd=%h cnt=%0d done=%0b err=%0b",
                     mem_we, in_ready, mem_wdata, count, done, err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        settle(1);
    endtask

    task automatic test_start_collide();
        clear_log();
        do_start();
        @(negedge clk);
        in_fmt = 2'd3;
        in_opcode = 6'b000001;
        in_imm = 32'd1;
        in_last = 1'b1;
        in_valid = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b0;
        in_last = 1'b0;
        settle(3);
        checks++;
        if (nwr !== 0 || count !== 11'd0 || in_ready !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL start_collide: n=%0d cnt=%0d rdy=%0b done=%0b required 0/0/1/0",
                     nwr, count, in_ready, done);
        end
    endtask

    initial begin
        test_reset();
        test_single_lw();
        test_back_to_back();
        test_range_err();
        test_fmt_err();
        test_overflow();
        test_reset_mid();
        test_start_collide();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
